bundle_parser: RTL

- Parametrised, N-wide successor to the dual-issue parser.
- Splits one fetched bundle of variable-length instructions (short and long formats) into ISSUE_WIDTH decoded slots.
- Each slot carries branch, format, opcode, register and operand fields, plus the bundle's consumed byte count.
- Sits between fetch and the dependency checker. Two-stage pipeline with full valid/ready backpressure and flush.

---
 rtl/bundle_parser_pkg.sv | 35 +++
 rtl/bundle_slot_extract.sv | 53 +++++
 rtl/bundle_parser.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/bundle_parser_pkg.sv
// Shared field widths, slot record and length helpers for the bundle parser.
package bundle_parser_pkg;

  localparam int OPCODE_W = 7;
  localparam int REG_W    = 5;
  localparam int IMM_W    = 16;
  localparam int POS_W    = 16;

  typedef logic signed [POS_W-1:0] pos_t;

  typedef struct packed {
    logic                fmt;
    logic                br;
    logic [OPCODE_W-1:0] opc;
    logic [REG_W-1:0]    rg;
    logic [IMM_W-1:0]    opnd;
    logic                vld;
  } slot_t;

  function automatic int short_len();
    return 2 + OPCODE_W + 2 * REG_W;
  endfunction

  function automatic int long_len();
    return 2 + OPCODE_W + REG_W + IMM_W;
  endfunction

  localparam int SHORT_LEN = short_len();
  localparam int LONG_LEN  = long_len();

  function automatic logic [POS_W-1:0] bytes_ceil(input logic [POS_W-1:0] bits);
    return (bits + POS_W'(7)) >> 3;
  endfunction

endpackage

// File: rtl/bundle_slot_extract.sv
// Pulls one instruction out of a bundle given the bit position of its format bit.
module bundle_slot_extract
  import bundle_parser_pkg::*;
#(
  parameter int BUNDLE_BITS = 64
) (
  input  logic [BUNDLE_BITS-1:0] i_bundle,
  input  logic [POS_W-1:0]       i_pos,
  input  logic                   i_prevVld,
  output logic                   o_fmt,
  output logic                   o_br,
  output logic [OPCODE_W-1:0]    o_opc,
  output logic [REG_W-1:0]       o_rg,
  output logic [IMM_W-1:0]       o_opnd,
  output logic                   o_vld,
  output logic [POS_W-1:0]       o_len
);

  localparam pos_t TOP_POS = pos_t'(BUNDLE_BITS - 1);
  localparam int   OPC_TOP = BUNDLE_BITS - 3;
  localparam int   REG_TOP = OPC_TOP - OPCODE_W;
  localparam int   OPD_TOP = REG_TOP - REG_W;

  pos_t                   w_pos;
  pos_t                   w_len;
  logic                   w_inRange;
  logic [POS_W-1:0]       w_shift;
  logic [BUNDLE_BITS-1:0] w_aligned;
  logic                   w_fmt;
  logic                   w_vld;

  // Left-align the slot so its format bit lands on the bundle MSB.
  assign w_pos     = i_pos;
  assign w_inRange = (w_pos >= pos_t'(0)) && (w_pos <= TOP_POS);
  assign w_shift   = w_inRange ? (TOP_POS - w_pos) : '0;
  assign w_aligned = i_bundle << w_shift;

  assign w_fmt = w_aligned[BUNDLE_BITS-1];
  assign w_len = w_fmt ? pos_t'(LONG_LEN) : pos_t'(SHORT_LEN);
  assign w_vld = i_prevVld & w_inRange & (w_pos >= w_len - pos_t'(1));

  // A slot that does not fit, or follows one that did not, reads as all zero.
  assign o_fmt  = w_vld & w_fmt;
  assign o_br   = w_vld & w_aligned[BUNDLE_BITS-2];
  assign o_opc  = w_vld ? w_aligned[OPC_TOP -: OPCODE_W] : '0;
  assign o_rg   = w_vld ? w_aligned[REG_TOP -: REG_W] : '0;
  assign o_opnd = !w_vld ? '0 :
                  w_fmt  ? w_aligned[OPD_TOP -: IMM_W] :
                           IMM_W'(w_aligned[OPD_TOP -: REG_W]);
  assign o_vld  = w_vld;
  assign o_len  = w_len;

endmodule

// File: rtl/bundle_parser.sv
// Two-stage parser: captures a fetched bundle, then registers its decoded slots.
module bundle_parser
  import bundle_parser_pkg::*;
#(
  parameter int  ISSUE_WIDTH = 2,
  parameter int  BUNDLE_BITS = 64,
  parameter int  RSVD_BITS   = 4,
  localparam int SIZE_W      = $clog2(BUNDLE_BITS / 8) + 1
) (
  input  logic                            clock_i,
  input  logic                            reset_i,
  input  logic                            flushBack_i,
  input  logic [BUNDLE_BITS-1:0]          instruction_i,
  input  logic                            inValid_i,
  output logic                            inReady_o,
  output logic                            outValid_o,
  input  logic                            outReady_i,
  output logic [ISSUE_WIDTH-1:0]          slotValid_o,
  output logic [ISSUE_WIDTH-1:0]          isBranch_o,
  output logic [ISSUE_WIDTH-1:0]          instructionFormat_o,
  output logic [ISSUE_WIDTH*OPCODE_W-1:0] opcode_o,
  output logic [ISSUE_WIDTH*REG_W-1:0]    reg_o,
  output logic [ISSUE_WIDTH*IMM_W-1:0]    operand_o,
  output logic [SIZE_W-1:0]               fetchedBundleSize_o
);

  logic                            r_s1Valid;
  logic [BUNDLE_BITS-1:0]          r_s1Bundle;
  logic                            r_outValid;
  logic [ISSUE_WIDTH-1:0]          r_slotValid;
  logic [ISSUE_WIDTH-1:0]          r_isBranch;
  logic [ISSUE_WIDTH-1:0]          r_format;
  logic [ISSUE_WIDTH*OPCODE_W-1:0] r_opcode;
  logic [ISSUE_WIDTH*REG_W-1:0]    r_reg;
  logic [ISSUE_WIDTH*IMM_W-1:0]    r_operand;
  logic [SIZE_W-1:0]               r_size;

  logic                            w_s1Advance;
  logic                            w_inReady;
  logic                            w_accept;
  slot_t [ISSUE_WIDTH-1:0]         w_slot;
  logic [ISSUE_WIDTH-1:0][POS_W-1:0] w_pos;
  logic [ISSUE_WIDTH-1:0][POS_W-1:0] w_len;
  logic [ISSUE_WIDTH-1:0]          w_prevVld;
  logic [ISSUE_WIDTH-1:0]          w_slotValid;
  logic [ISSUE_WIDTH-1:0]          w_isBranch;
  logic [ISSUE_WIDTH-1:0]          w_format;
  logic [ISSUE_WIDTH*OPCODE_W-1:0] w_opcode;
  logic [ISSUE_WIDTH*REG_W-1:0]    w_reg;
  logic [ISSUE_WIDTH*IMM_W-1:0]    w_operand;
  logic [POS_W-1:0]                w_sumBits;
  logic [SIZE_W-1:0]               w_size;

  assign w_s1Advance = r_s1Valid & (~r_outValid | outReady_i);
  assign w_inReady   = ~flushBack_i & (~r_s1Valid | w_s1Advance);
  assign w_accept    = inValid_i & w_inReady;

  assign w_pos[0] = POS_W'(BUNDLE_BITS - 1 - RSVD_BITS);

  // Each slot starts where the previous one ended; validity ripples the same way.
  for (genvar k = 0; k < ISSUE_WIDTH; k++) begin : g_slot
    if (k == 0) begin : g_first
      assign w_prevVld[k] = 1'b1;
    end else begin : g_rest
      assign w_prevVld[k] = w_slot[k-1].vld;
    end

    bundle_slot_extract #(
      .BUNDLE_BITS(BUNDLE_BITS)
    ) u_extract (
      .i_bundle (r_s1Bundle),
      .i_pos    (w_pos[k]),
      .i_prevVld(w_prevVld[k]),
      .o_fmt    (w_slot[k].fmt),
      .o_br     (w_slot[k].br),
      .o_opc    (w_slot[k].opc),
      .o_rg     (w_slot[k].rg),
      .o_opnd   (w_slot[k].opnd),
      .o_vld    (w_slot[k].vld),
      .o_len    (w_len[k])
    );

    if (k < ISSUE_WIDTH - 1) begin : g_next
      assign w_pos[k+1] = w_pos[k] - w_len[k];
    end
  end

  always_comb begin
    w_slotValid = '0;
    w_isBranch  = '0;
    w_format    = '0;
    w_opcode    = '0;
    w_reg       = '0;
    w_operand   = '0;
    w_sumBits   = '0;
    for (int k = 0; k < ISSUE_WIDTH; k++) begin
      w_slotValid[k]                     = w_slot[k].vld;
      w_isBranch[k]                      = w_slot[k].br;
      w_format[k]                        = w_slot[k].fmt;
      w_opcode[k*OPCODE_W +: OPCODE_W]   = w_slot[k].opc;
      w_reg[k*REG_W +: REG_W]            = w_slot[k].rg;
      w_operand[k*IMM_W +: IMM_W]        = w_slot[k].opnd;
      if (w_slot[k].vld) begin
        w_sumBits = w_sumBits + w_len[k];
      end
    end
    w_size = SIZE_W'(bytes_ceil(w_sumBits));
  end

  always_ff @(posedge clock_i) begin
    if (reset_i || flushBack_i) begin
      r_s1Valid  <= 1'b0;
      r_outValid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_s1Valid <= 1'b1;
      end else if (w_s1Advance) begin
        r_s1Valid <= 1'b0;
      end
      if (w_s1Advance) begin
        r_outValid <= 1'b1;
      end else if (outReady_i) begin
        r_outValid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (w_accept) begin
      r_s1Bundle <= instruction_i;
    end
  end

  // Decoded fields change only when a new bundle moves in, so a stall holds them.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_slotValid <= '0;
      r_isBranch  <= '0;
      r_format    <= '0;
      r_opcode    <= '0;
      r_reg       <= '0;
      r_operand   <= '0;
      r_size      <= '0;
    end else if (w_s1Advance && !flushBack_i) begin
      r_slotValid <= w_slotValid;
      r_isBranch  <= w_isBranch;
      r_format    <= w_format;
      r_opcode    <= w_opcode;
      r_reg       <= w_reg;
      r_operand   <= w_operand;
      r_size      <= w_size;
    end
  end

  assign inReady_o           = w_inReady;
  assign outValid_o          = r_outValid;
  assign slotValid_o         = r_slotValid;
  assign isBranch_o          = r_isBranch;
  assign instructionFormat_o = r_format;
  assign opcode_o            = r_opcode;
  assign reg_o               = r_reg;
  assign operand_o           = r_operand;
  assign fetchedBundleSize_o = r_size;

endmodule
